// File: rtl/program_loader.sv
// Boot loader: receives a length-prefixed byte stream, writes big-endian words to
// instruction memory, then releases the core. Optional trailing XOR checksum: LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int DEPTH_W = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_waddr,
  output logic [31:0] imem_wdata,
  output logic        cpu_enable,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int          KW        = DEPTH_W + 1;
  localparam logic [16:0] MAX_WORDS = 17'(1) << DEPTH_W;
  localparam logic [KW-1:0] K_ONE   = KW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_RUN    = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t          r_state;
  logic [7:0]      r_len_hi;
  logic [KW-1:0]   r_nwords;
  logic [KW-1:0]   r_k;
  logic [1:0]      r_bcnt;
  logic [23:0]     r_word;
  logic            r_rx_ready;
  logic            r_imem_we;
  logic [31:0]     r_imem_waddr;
  logic [31:0]     r_imem_wdata;
  logic            r_cpu_enable;
  logic            r_busy;
  logic            r_done;
  logic            r_err;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]      r_csum;
  logic [7:0]      w_csum_next;
`endif

  logic            w_xfer;
  logic [15:0]     w_len;
  logic            w_len_big;
  logic            w_len_zero;
  logic [KW-1:0]   w_k_next;

  assign w_xfer     = rx_valid & r_rx_ready;
  assign w_len      = {r_len_hi, rx_data};
  assign w_len_big  = ({1'b0, w_len} > MAX_WORDS);
  assign w_len_zero = (w_len == 16'd0);
  assign w_k_next   = r_k + K_ONE;
`ifdef LOADER_CHECKSUM_EN
  assign w_csum_next = r_csum ^ rx_data;
`endif

  // Session FSM; all status outputs are registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_len_hi     <= 8'd0;
      r_nwords     <= '0;
      r_k          <= '0;
      r_bcnt       <= 2'd0;
      r_word       <= 24'd0;
      r_rx_ready   <= 1'b0;
      r_imem_we    <= 1'b0;
      r_imem_waddr <= 32'd0;
      r_imem_wdata <= 32'd0;
      r_cpu_enable <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_csum       <= 8'd0;
`endif
    end else begin
      r_imem_we <= 1'b0;
      case (r_state)
        S_IDLE, S_RUN, S_ERR: begin
          if (start) begin
            r_state      <= S_LEN_HI;
            r_busy       <= 1'b1;
            r_rx_ready   <= 1'b1;
            r_cpu_enable <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_k          <= '0;
            r_bcnt       <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
            r_csum       <= 8'd0;
`endif
          end
        end
        S_LEN_HI: begin
          if (w_xfer) begin
            r_len_hi <= rx_data;
            r_state  <= S_LEN_LO;
`ifdef LOADER_CHECKSUM_EN
            r_csum   <= w_csum_next;
`endif
          end
        end
        S_LEN_LO: begin
          if (w_xfer) begin
            r_nwords <= w_len[KW-1:0];
`ifdef LOADER_CHECKSUM_EN
            r_csum   <= w_csum_next;
`endif
            if (w_len_big) begin
              r_state    <= S_ERR;
              r_busy     <= 1'b0;
              r_rx_ready <= 1'b0;
              r_err      <= 1'b1;
            end else if (w_len_zero) begin
`ifdef LOADER_CHECKSUM_EN
              r_state      <= S_CSUM;
`else
              r_state      <= S_RUN;
              r_busy       <= 1'b0;
              r_rx_ready   <= 1'b0;
              r_cpu_enable <= 1'b1;
              r_done       <= 1'b1;
`endif
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_word <= {r_word[15:0], rx_data};
            r_bcnt <= r_bcnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            r_csum <= w_csum_next;
`endif
            if (r_bcnt == 2'd3) begin
              r_imem_we    <= 1'b1;
              r_imem_waddr <= 32'({r_k, 2'b00});
              r_imem_wdata <= {r_word, rx_data};
              r_k          <= w_k_next;
              if (w_k_next == r_nwords) begin
`ifdef LOADER_CHECKSUM_EN
                r_state      <= S_CSUM;
`else
                r_state      <= S_RUN;
                r_busy       <= 1'b0;
                r_rx_ready   <= 1'b0;
                r_cpu_enable <= 1'b1;
                r_done       <= 1'b1;
`endif
              end
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (w_xfer) begin
            r_busy     <= 1'b0;
            r_rx_ready <= 1'b0;
            if (rx_data == r_csum) begin
              r_state      <= S_RUN;
              r_cpu_enable <= 1'b1;
              r_done       <= 1'b1;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_rx_ready <= 1'b0;
        end
      endcase
    end
  end

  assign rx_ready   = r_rx_ready;
  assign imem_we    = r_imem_we;
  assign imem_waddr = r_imem_waddr;
  assign imem_wdata = r_imem_wdata;
  assign cpu_enable = r_cpu_enable;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader (DEPTH_W=6); works with or
// without LOADER_CHECKSUM_EN.
module tb_program_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        cpu_enable;
  logic        busy;
  logic        done;
  logic        err;

  int          passed = 0;
  int          total  = 0;
  int          wr_cnt = 0;
  logic [7:0]  csum   = 8'd0;

  program_loader #(.DEPTH_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_enable (cpu_enable),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count write strobes, one per cycle they are high.
  always @(negedge clk) begin
    if (imem_we === 1'b1) wr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // {cpu_enable, done, busy, err, rx_ready}
  function automatic logic [31:0] status();
    return {27'd0, cpu_enable, done, busy, err, rx_ready};
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic begin_session();
    pulse_start();
    csum = 8'd0;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    csum     = csum ^ b;
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send(w[31:24]);
    send(w[23:16]);
    send(w[15:8]);
    send(w[7:0]);
  endtask

  task automatic finish_image();
`ifdef LOADER_CHECKSUM_EN
    send(csum);
`endif
  endtask

  task automatic check_writes(input string tag, input int exp);
    #1;
    check(tag, 32'(wr_cnt), 32'(exp));
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    repeat (2) @(negedge clk);
    check("reset_status", {26'd0, rx_ready, imem_we, cpu_enable, busy, done, err}, 32'd0);
    check("reset_waddr", imem_waddr, 32'd0);
    check("reset_wdata", imem_wdata, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_no_ready", status(), 32'b00000);

    // Two-word image; a start inside DATA must be ignored.
    begin_session();
    check("start_busy", status(), 32'b00101);
    send(8'h00);
    send(8'h02);
    send_word(32'h2001_0005);
    check("w0_we", {31'd0, imem_we}, 32'd1);
    check("w0_addr", imem_waddr, 32'h0);
    check("w0_data", imem_wdata, 32'h2001_0005);
    @(negedge clk);
    check("w0_we_one_cycle", {31'd0, imem_we}, 32'd0);
    check("w0_addr_hold", imem_waddr, 32'h0);
    check("w0_data_hold", imem_wdata, 32'h2001_0005);
    send(8'h08);
    pulse_start();
    check("start_in_data_ignored", status(), 32'b00101);
    send(8'h00);
    send(8'h00);
    send(8'h00);
    check("w1_we", {31'd0, imem_we}, 32'd1);
    check("w1_addr", imem_waddr, 32'h4);
    check("w1_data", imem_wdata, 32'h0800_0000);
    finish_image();
    check("img1_run", status(), 32'b11000);
    check_writes("img1_writes", 2);

    // Restart from RUN, then oversize length 0x0041.
    @(negedge clk);
    begin_session();
    check("restart_from_run", status(), 32'b00101);
    send(8'h00);
    send(8'h41);
    check("oversize_err", status(), 32'b00010);
    check("oversize_no_we", {31'd0, imem_we}, 32'd0);
    check_writes("oversize_writes", 2);

    // Restart from ERR, then N=0.
    @(negedge clk);
    begin_session();
    check("restart_from_err", status(), 32'b00101);
    send(8'h00);
    send(8'h00);
    finish_image();
    check("n0_run", status(), 32'b11000);
    check_writes("n0_writes", 2);

    // Reload restarts at address 0.
    @(negedge clk);
    begin_session();
    send(8'h00);
    send(8'h01);
    send_word(32'hDEAD_BEEF);
    check("reload_addr", imem_waddr, 32'h0);
    check("reload_data", imem_wdata, 32'hDEAD_BEEF);
    finish_image();
    check("reload_run", status(), 32'b11000);
    check_writes("reload_writes", 3);

`ifdef LOADER_CHECKSUM_EN
    @(negedge clk);
    begin_session();
    send(8'h00);
    send(8'h01);
    send_word(32'h1234_5678);
    send(csum ^ 8'hFF);
    check("bad_csum_err", status(), 32'b00010);
    check_writes("bad_csum_writes", 4);
    wr_cnt = wr_cnt - 1;
`endif

    // Largest legal image: 64 words.
    @(negedge clk);
    begin_session();
    send(8'h00);
    send(8'h40);
    for (int k = 0; k < 64; k++) begin
      send_word({8'(k), 8'h5A, 8'hC3, ~8'(k)});
    end
    check("max_last_addr", imem_waddr, 32'h0000_00FC);
    check("max_last_data", imem_wdata, 32'h3F5A_C3C0);
    finish_image();
    check("max_run", status(), 32'b11000);
    check_writes("max_writes", 67);

    // Asynchronous reset in the middle of a session with rx_valid held high.
    @(negedge clk);
    begin_session();
    send(8'h00);
    send(8'h01);
    send(8'h11);
    rx_valid = 1'b1;
    rx_data  = 8'h22;
    #2;
    reset = 1'b0;
    #1;
    check("midreset_status", {26'd0, rx_ready, imem_we, cpu_enable, busy, done, err}, 32'd0);
    check("midreset_waddr", imem_waddr, 32'd0);
    check("midreset_wdata", imem_wdata, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_no_ready", status(), 32'b00000);
    rx_valid = 1'b0;
    check_writes("post_reset_writes", 67);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
